// File: rtl/bconv_stream_layer.sv
// Streaming KxK binary convolution: line buffers build a sliding window, each channel XNOR-popcounts it against fixed weights and thresholds.
// Latency: conv_out/out_valid register on the same edge that accepts the window-completing pixel (1 cycle).
// Backpressure: none downstream; in_valid low freezes counters, line buffers and window, drops out_valid and holds conv_out.
module bconv_stream_layer #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 3,
    parameter int N_CH  = 8,
    parameter int CW    = $clog2(K*K+1),
    parameter logic [N_CH*K*K-1:0] WEIGHTS = '1,
    parameter logic [N_CH*CW-1:0]  THRESH  = {N_CH{CW'(5)}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pixel_in,
    input  logic            in_valid,
    output logic [N_CH-1:0] conv_out,
    output logic            out_valid,
    output logic            frame_done
);

    localparam int KK    = K*K;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W-1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H-1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K-1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K-1);

    logic [COL_W-1:0]            col_q, col_d;
    logic [ROW_W-1:0]            row_q, row_d;
    logic [K-2:0][IMG_W-1:0]     lb_q, lb_d;
    logic [K-1:0][K-1:0]         win_q, win_d;
    logic [K-1:0]                new_col;
    logic [KK-1:0]               win_flat;
    logic [N_CH-1:0]             conv_q, conv_d;
    logic                        out_valid_q, frame_done_q;
    logic                        col_last, row_last, win_ok;

    function automatic logic [CW-1:0] popcnt(input logic [KK-1:0] v);
        logic [CW-1:0] s;
        s = '0;
        for (int i = 0; i < KK; i++) begin
            s = s + CW'(v[i]);
        end
        return s;
    endfunction

    always_comb begin
        col_last = (col_q == COL_LAST);
        row_last = (row_q == ROW_LAST);
        win_ok   = in_valid && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
        col_d    = col_q;
        row_d    = row_q;
        if (in_valid) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Tap i of line buffer i is the pixel (i+1) rows above the incoming one.
    always_comb begin
        new_col = '0;
        new_col[K-1] = pixel_in;
        for (int r = 0; r < K-1; r++) begin
            new_col[r] = lb_q[K-2-r][IMG_W-1];
        end
    end

    always_comb begin
        lb_d  = lb_q;
        win_d = win_q;
        if (in_valid) begin
            lb_d[0] = {lb_q[0][IMG_W-2:0], pixel_in};
            for (int i = 1; i < K-1; i++) begin
                lb_d[i] = {lb_q[i][IMG_W-2:0], lb_q[i-1][IMG_W-1]};
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K-1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][K-1] = new_col[r];
            end
        end
    end

    // Channels evaluate the next window so the result registers with the pixel itself.
    assign win_flat = win_d;

    always_comb begin
        conv_d = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            conv_d[ch] = popcnt(~(win_flat ^ WEIGHTS[ch*KK +: KK])) >= THRESH[ch*CW +: CW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            conv_q       <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= win_ok;
            frame_done_q <= in_valid && col_last && row_last;
            if (win_ok) begin
                conv_q <= conv_d;
            end
        end
    end

    // Storage is never exposed before it is refilled, so it carries no reset.
    always_ff @(posedge clk) begin
        lb_q  <= lb_d;
        win_q <= win_d;
    end

    assign conv_out   = conv_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bconv_stream_layer.sv
// Bench for bconv_stream_layer: several configurations driven from one stimulus stream, checked against a window-level model.
module tb_bconv_stream_layer;

    localparam logic [71:0] W_ALL1 = '1;
    localparam logic [71:0] W_ASYM = 72'hA53C96F00F5AC37E19;
    localparam logic [31:0] THR5   = {8{4'd5}};
    localparam logic [31:0] THR_W  = {4'd0, 4'd10, 4'd9, 4'd1, 4'd7, 4'd3, 4'd5, 4'd4};
    localparam logic [31:0] THR_S  = 32'h19;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, pixel_in, in_valid;
    logic [7:0] co_a, co_z9, co_z10, co_w;
    logic       ov_a, fd_a, ov_z9, fd_z9, ov_z10, fd_z10, ov_w, fd_w;
    logic       rst_s_n, pix_s, iv_s;
    logic [1:0] co_s;
    logic       ov_s, fd_s;

    bconv_stream_layer dut_a (.clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .in_valid(in_valid),
                              .conv_out(co_a), .out_valid(ov_a), .frame_done(fd_a));
    bconv_stream_layer #(.WEIGHTS('0), .THRESH({8{4'd9}})) dut_z9 (.clk(clk), .rst_n(rst_n),
        .pixel_in(pixel_in), .in_valid(in_valid), .conv_out(co_z9), .out_valid(ov_z9), .frame_done(fd_z9));
    bconv_stream_layer #(.WEIGHTS('0), .THRESH({8{4'd10}})) dut_z10 (.clk(clk), .rst_n(rst_n),
        .pixel_in(pixel_in), .in_valid(in_valid), .conv_out(co_z10), .out_valid(ov_z10), .frame_done(fd_z10));
    bconv_stream_layer #(.WEIGHTS(W_ASYM), .THRESH(THR_W)) dut_w (.clk(clk), .rst_n(rst_n),
        .pixel_in(pixel_in), .in_valid(in_valid), .conv_out(co_w), .out_valid(ov_w), .frame_done(fd_w));
    bconv_stream_layer #(.IMG_W(5), .IMG_H(4), .K(3), .N_CH(2), .WEIGHTS(18'h001FF), .THRESH(8'h19)) dut_s (
        .clk(clk), .rst_n(rst_s_n), .pixel_in(pix_s), .in_valid(iv_s),
        .conv_out(co_s), .out_valid(ov_s), .frame_done(fd_s));

    bit         img [0:27][0:27];
    logic [7:0] q_a[$], q_z9[$], q_z10[$], q_w[$], exp_q[$];
    logic [1:0] q_s[$];
    bit         f_a[$], f_s[$];
    int         n_cmp = 0, n_fail = 0;
    int         stray_a = 0, stray_s = 0, order_viol = 0, hold_viol = 0;
    logic       iv_prev = 1'b0;
    logic [7:0] co_prev = '0;

    always @(negedge clk) begin
        if (ov_a) begin
            q_a.push_back(co_a);
            f_a.push_back(fd_a);
        end else if (fd_a) begin
            stray_a++;
        end
        if (ov_a && !iv_prev) order_viol++;
        if (!iv_prev && !ov_a && rst_n && co_a !== co_prev) hold_viol++;
        iv_prev = in_valid;
        co_prev = co_a;
        if (ov_z9)  q_z9.push_back(co_z9);
        if (ov_z10) q_z10.push_back(co_z10);
        if (ov_w)   q_w.push_back(co_w);
        if (ov_s) begin
            q_s.push_back(co_s);
            f_s.push_back(fd_s);
        end else if (fd_s) begin
            stray_s++;
        end
    end

    // Result for the window whose top-left pixel is (r,c); weight bit dr*3+dc, dr=0 is the top row.
    function automatic logic [7:0] ref_out(input int r, input int c, input int nch,
                                           input logic [71:0] wts, input logic [31:0] thr);
        logic [7:0] res;
        int pc;
        res = '0;
        for (int ch = 0; ch < nch; ch++) begin
            pc = 0;
            for (int dr = 0; dr < 3; dr++)
                for (int dc = 0; dc < 3; dc++)
                    if (img[r+dr][c+dc] == wts[ch*9 + dr*3 + dc]) pc++;
            if (pc >= int'(thr[ch*4 +: 4])) res[ch] = 1'b1;
        end
        return res;
    endfunction

    task automatic fill_exp(input int w, input int h, input int nch, input logic [71:0] wts, input logic [31:0] thr);
        exp_q.delete();
        for (int r = 0; r <= h-3; r++)
            for (int c = 0; c <= w-3; c++)
                exp_q.push_back(ref_out(r, c, nch, wts, thr));
    endtask

    task automatic clear_all();
        q_a.delete(); f_a.delete(); q_z9.delete(); q_z10.delete(); q_w.delete();
        q_s.delete(); f_s.delete();
        stray_a = 0; stray_s = 0; order_viol = 0; hold_viol = 0;
    endtask

    task automatic cyc(input logic v, input logic p);
        @(posedge clk); #1;
        in_valid = v;
        pixel_in = p;
    endtask

    task automatic cyc_s(input logic v, input logic p);
        @(posedge clk); #1;
        iv_s  = v;
        pix_s = p;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'($urandom));
    endtask

    // mode 0: continuous, 1: alternate idle cycle, 2: random idle gaps
    task automatic drive_frame(input int mode);
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++) begin
                cyc(1'b1, img[r][c]);
                if (mode == 1) cyc(1'b0, 1'($urandom));
                else if (mode == 2) while ($urandom_range(0, 2) == 0) cyc(1'b0, 1'($urandom));
            end
    endtask

    task automatic drive_small(input int mode);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++) begin
                cyc_s(1'b1, img[r][c]);
                if (mode == 2) while ($urandom_range(0, 2) == 0) cyc_s(1'b0, 1'($urandom));
            end
        repeat (4) cyc_s(1'b0, 1'b0);
    endtask

    task automatic set_checker();
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                img[r][c] = bit'((r + c) % 2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_s_n = 1'b0;
        in_valid = 1'b0; pixel_in = 1'b0; iv_s = 1'b0; pix_s = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++; if (co_a !== 8'h00) begin n_fail++; $display("FAIL reset_conv_out: got %h want 00", co_a); end
        n_cmp++; if (ov_a !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", ov_a); end
        n_cmp++; if (fd_a !== 1'b0)  begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", fd_a); end
        n_cmp++; if ({co_s, ov_s, fd_s} !== 4'b0) begin n_fail++; $display("FAIL reset_small: got %b want 0000", {co_s, ov_s, fd_s}); end
        rst_n = 1'b1; rst_s_n = 1'b1;
        idle(2);
    endtask

    task automatic test_checkerboard();
        set_checker();
        clear_all();
        drive_frame(0);
        idle(4);
        fill_exp(28, 28, 8, W_ALL1, THR5);
        n_cmp++; if (q_a.size() != 676) begin n_fail++; $display("FAIL ckb_count: got %0d want 676", q_a.size()); end
        for (int i = 0; i < exp_q.size() && i < q_a.size(); i++) begin
            n_cmp++; if (q_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL ckb_result[%0d]: got %h want %h", i, q_a[i], exp_q[i]); end
            n_cmp++; if (f_a[i] !== (i == 675)) begin n_fail++; $display("FAIL ckb_frame_done[%0d]: got %b want %b", i, f_a[i], i == 675); end
        end
        n_cmp++; if (stray_a != 0) begin n_fail++; $display("FAIL ckb_stray_done: got %0d want 0", stray_a); end
    endtask

    task automatic test_toggle();
        set_checker();
        clear_all();
        drive_frame(1);
        idle(4);
        fill_exp(28, 28, 8, W_ALL1, THR5);
        n_cmp++; if (q_a.size() != 676) begin n_fail++; $display("FAIL tog_count: got %0d want 676", q_a.size()); end
        for (int i = 0; i < exp_q.size() && i < q_a.size(); i++) begin
            n_cmp++; if (q_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL tog_result[%0d]: got %h want %h", i, q_a[i], exp_q[i]); end
        end
        n_cmp++; if (order_viol != 0) begin n_fail++; $display("FAIL tog_valid_after_idle: got %0d want 0", order_viol); end
        n_cmp++; if (hold_viol != 0)  begin n_fail++; $display("FAIL tog_hold: got %0d want 0", hold_viol); end
    endtask

    task automatic test_random_image();
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                img[r][c] = bit'($urandom_range(0, 1));
        clear_all();
        drive_frame(2);
        idle(4);
        fill_exp(28, 28, 8, W_ALL1, THR5);
        n_cmp++; if (q_a.size() != 676) begin n_fail++; $display("FAIL rnd_count: got %0d want 676", q_a.size()); end
        for (int i = 0; i < exp_q.size() && i < q_a.size(); i++) begin
            n_cmp++; if (q_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_result[%0d]: got %h want %h", i, q_a[i], exp_q[i]); end
        end
        fill_exp(28, 28, 8, W_ASYM, THR_W);
        n_cmp++; if (q_w.size() != 676) begin n_fail++; $display("FAIL rnd_w_count: got %0d want 676", q_w.size()); end
        for (int i = 0; i < exp_q.size() && i < q_w.size(); i++) begin
            n_cmp++; if (q_w[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_w_result[%0d]: got %h want %h", i, q_w[i], exp_q[i]); end
        end
    endtask

    task automatic test_zero_image();
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                img[r][c] = 1'b0;
        clear_all();
        drive_frame(0);
        idle(4);
        fill_exp(28, 28, 8, '0, {8{4'd9}});
        n_cmp++; if (q_z9.size() != 676) begin n_fail++; $display("FAIL zero9_count: got %0d want 676", q_z9.size()); end
        for (int i = 0; i < exp_q.size() && i < q_z9.size(); i++) begin
            n_cmp++; if (q_z9[i] !== exp_q[i]) begin n_fail++; $display("FAIL zero9_result[%0d]: got %h want %h", i, q_z9[i], exp_q[i]); end
        end
        fill_exp(28, 28, 8, '0, {8{4'd10}});
        n_cmp++; if (q_z10.size() != 676) begin n_fail++; $display("FAIL zero10_count: got %0d want 676", q_z10.size()); end
        for (int i = 0; i < exp_q.size() && i < q_z10.size(); i++) begin
            n_cmp++; if (q_z10[i] !== exp_q[i]) begin n_fail++; $display("FAIL zero10_result[%0d]: got %h want %h", i, q_z10[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        set_checker();
        for (int i = 0; i < 100; i++) cyc(1'b1, img[i / 28][i % 28]);
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if ({co_a, ov_a, fd_a} !== 10'b0) begin n_fail++; $display("FAIL midrst_async: got %h want 000", {co_a, ov_a, fd_a}); end
        repeat (2) @(posedge clk);
        #2;
        n_cmp++; if ({co_a, ov_a, fd_a} !== 10'b0) begin n_fail++; $display("FAIL midrst_held: got %h want 000", {co_a, ov_a, fd_a}); end
        rst_n = 1'b1;
        clear_all();
        drive_frame(0);
        idle(4);
        fill_exp(28, 28, 8, W_ALL1, THR5);
        n_cmp++; if (q_a.size() != 676) begin n_fail++; $display("FAIL midrst_count: got %0d want 676", q_a.size()); end
        for (int i = 0; i < exp_q.size() && i < q_a.size(); i++) begin
            n_cmp++; if (q_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_result[%0d]: got %h want %h", i, q_a[i], exp_q[i]); end
            n_cmp++; if (f_a[i] !== (i == 675)) begin n_fail++; $display("FAIL midrst_frame_done[%0d]: got %b want %b", i, f_a[i], i == 675); end
        end
    endtask

    task automatic test_back_to_back();
        set_checker();
        clear_all();
        drive_frame(0);
        drive_frame(0);
        idle(4);
        fill_exp(28, 28, 8, W_ALL1, THR5);
        n_cmp++; if (q_a.size() != 1352) begin n_fail++; $display("FAIL b2b_count: got %0d want 1352", q_a.size()); end
        for (int i = 0; i < 1352 && i < q_a.size(); i++) begin
            n_cmp++; if (q_a[i] !== exp_q[i % 676]) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h want %h", i, q_a[i], exp_q[i % 676]); end
            n_cmp++; if (f_a[i] !== (i % 676 == 675)) begin n_fail++; $display("FAIL b2b_frame_done[%0d]: got %b want %b", i, f_a[i], i % 676 == 675); end
        end
        n_cmp++; if (stray_a != 0) begin n_fail++; $display("FAIL b2b_stray_done: got %0d want 0", stray_a); end
    endtask

    task automatic test_small_config();
        for (int pass = 0; pass < 2; pass++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 5; c++)
                    img[r][c] = (pass == 0) ? 1'b1 : bit'($urandom_range(0, 1));
            clear_all();
            drive_small(pass == 0 ? 0 : 2);
            fill_exp(5, 4, 2, {54'b0, 18'h001FF}, THR_S);
            n_cmp++; if (q_s.size() != 6) begin n_fail++; $display("FAIL small%0d_count: got %0d want 6", pass, q_s.size()); end
            for (int i = 0; i < exp_q.size() && i < q_s.size(); i++) begin
                n_cmp++; if (q_s[i] !== exp_q[i][1:0]) begin n_fail++; $display("FAIL small%0d_result[%0d]: got %b want %b", pass, i, q_s[i], exp_q[i][1:0]); end
                n_cmp++; if (f_s[i] !== (i == 5)) begin n_fail++; $display("FAIL small%0d_frame_done[%0d]: got %b want %b", pass, i, f_s[i], i == 5); end
            end
            n_cmp++; if (stray_s != 0) begin n_fail++; $display("FAIL small%0d_stray_done: got %0d want 0", pass, stray_s); end
        end
    endtask

    initial begin
        test_reset();
        test_checkerboard();
        test_toggle();
        test_random_image();
        test_zero_image();
        test_reset_mid_frame();
        test_back_to_back();
        test_small_config();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
